// File: rtl/atom_npu_pkg.sv
// Shared types and arithmetic for the single-neuron NPU tile: opcodes, widths,
// accumulator rails and the saturating adder used by MAC and BIAS.
package atom_npu_pkg;

  localparam int unsigned ACC_W = 20;
  localparam int unsigned NUM_W = 4;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    OpNop   = 3'b000,
    OpLoadw = 3'b001,
    OpMac   = 3'b010,
    OpClr   = 3'b011,
    OpBias  = 3'b100,
    OpOut   = 3'b101,
    OpOuts  = 3'b110,
    OpStat  = 3'b111
  } opcode_e;

  typedef struct packed {
    logic             ovf;
    logic [ACC_W-1:0] sum;
  } sat_res_t;

  // One guard bit is enough: overflow iff the top two bits of the sum disagree.
  function automatic sat_res_t sat_add(input logic signed [ACC_W-1:0] a,
                                       input logic signed [ACC_W-1:0] b);
    logic [ACC_W:0] full;
    sat_res_t       res;
    full    = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    res.ovf = full[ACC_W] ^ full[ACC_W-1];
    if (!res.ovf) begin
      res.sum = full[ACC_W-1:0];
    end else if (full[ACC_W]) begin
      res.sum = ACC_MIN;
    end else begin
      res.sum = ACC_MAX;
    end
    return res;
  endfunction

endpackage

// File: rtl/atom_npu_mac.sv
// Combinational datapath: signed 8x8 multiply (or operand << 8 for bias) followed
// by a saturating accumulator add.
module atom_npu_mac
  import atom_npu_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic        [7:0]       operand_i,
  input  logic        [7:0]       weight_i,
  input  logic                    bias_i,
  output logic signed [ACC_W-1:0] acc_o,
  output logic                    ovf_o
);

  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] addend;
  sat_res_t                res;

  assign prod = $signed(operand_i) * $signed(weight_i);

  always_comb begin
    if (bias_i) begin
      addend = {{(ACC_W-16){operand_i[7]}}, operand_i, 8'h00};
    end else begin
      addend = {{(ACC_W-16){prod[15]}}, prod};
    end
  end

  assign res   = sat_add(acc_i, addend);
  assign acc_o = res.sum;
  assign ovf_o = res.ovf;

endmodule

// File: rtl/tt_um_atom_npu.sv
// TinyTapeout user tile: weight file, command decoder, quantiser and registered
// output around the saturating MAC datapath.
module tt_um_atom_npu
  import atom_npu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic signed [ACC_W-1:0] OutMax = 127;
  localparam logic signed [ACC_W-1:0] OutMin = -128;

  opcode_e    op;
  logic [1:0] idx;
  logic [2:0] sh;

  assign op  = opcode_e'(uio_in[2:0]);
  assign idx = uio_in[4:3];
  assign sh  = uio_in[7:5];

  logic signed [7:0]       w_q [NUM_W];
  logic signed [7:0]       w_d [NUM_W];
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic [7:0]              uo_q, uo_d;

  logic signed [ACC_W-1:0] mac_acc;
  logic                    mac_ovf;

  atom_npu_mac u_mac (
    .acc_i     (acc_q),
    .operand_i (ui_in),
    .weight_i  (w_q[idx]),
    .bias_i    (op == OpBias),
    .acc_o     (mac_acc),
    .ovf_o     (mac_ovf)
  );

  logic signed [ACC_W-1:0] shifted;
  logic [7:0]              q_relu, q_signed;

  assign shifted = acc_q >>> sh;

  always_comb begin
    if (shifted[ACC_W-1]) begin
      q_relu = 8'h00;
    end else if (shifted > OutMax) begin
      q_relu = 8'h7f;
    end else begin
      q_relu = shifted[7:0];
    end

    if (shifted > OutMax) begin
      q_signed = 8'h7f;
    end else if (shifted < OutMin) begin
      q_signed = 8'h80;
    end else begin
      q_signed = shifted[7:0];
    end
  end

  always_comb begin
    w_d   = w_q;
    acc_d = acc_q;
    sat_d = sat_q;
    uo_d  = uo_q;
    if (ena) begin
      case (op)
        OpLoadw: w_d[idx] = ui_in;
        OpMac, OpBias: begin
          acc_d = mac_acc;
          sat_d = sat_q | mac_ovf;
        end
        OpClr: begin
          acc_d = '0;
          sat_d = 1'b0;
        end
        OpOut:   uo_d = q_relu;
        OpOuts:  uo_d = q_signed;
        OpStat:  uo_d = {sat_q, acc_q[ACC_W-1], acc_q == '0, 5'b0};
        default: ;
      endcase
    end
  end

  // Reset is synchronous and active-high despite the harness name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_W; i++) begin
        w_q[i] <= '0;
      end
      acc_q <= '0;
      sat_q <= 1'b0;
      uo_q  <= 8'h00;
    end else begin
      w_q   <= w_d;
      acc_q <= acc_d;
      sat_q <= sat_d;
      uo_q  <= uo_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_atom_npu.sv
// Bench for tt_um_atom_npu: directed literal checks plus randomized commands
// compared every cycle against an integer reference model.
module tb_tt_um_atom_npu;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  tt_um_atom_npu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit check_en = 1'b0;

  // Reference model state.
  int mw[4];
  int macc;
  bit msat;
  int muo;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void model_acc_add(input int v);
    int s;
    s = macc + v;
    if (s > 524287 || s < -524288) msat = 1'b1;
    macc = clamp(s, -524288, 524287);
  endfunction

  function automatic void model_step(input int op, input int idx, input int sh, input int x,
                                     input bit en, input bit rst);
    if (rst) begin
      for (int i = 0; i < 4; i++) mw[i] = 0;
      macc = 0;
      msat = 1'b0;
      muo  = 0;
    end else if (en) begin
      case (op)
        1: mw[idx] = x;
        2: model_acc_add(x * mw[idx]);
        3: begin macc = 0; msat = 1'b0; end
        4: model_acc_add(x * 256);
        5: muo = clamp(macc >>> sh, 0, 127);
        6: muo = clamp(macc >>> sh, -128, 127) & 255;
        7: muo = (msat ? 128 : 0) + (macc < 0 ? 64 : 0) + (macc == 0 ? 32 : 0);
        default: ;
      endcase
    end
  endfunction

  task automatic cmd(input int op, input int idx, input int sh, input int x,
                     input bit en = 1'b1, input bit rst = 1'b0);
    logic [2:0] op_b;
    logic [1:0] idx_b;
    logic [2:0] sh_b;
    logic [7:0] x_b;
    op_b  = op[2:0];
    idx_b = idx[1:0];
    sh_b  = sh[2:0];
    x_b   = x[7:0];
    @(negedge clk);
    rst_n  = rst;
    ena    = en;
    uio_in = {sh_b, idx_b, op_b};
    ui_in  = x_b;
    @(posedge clk);
    model_step(op, idx, sh, x, en, rst);
  endtask

  task automatic expect_uo(input string name, input int exp);
    logic [7:0] e;
    e = exp[7:0];
    #1;
    check(name, uo_out, e);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      logic [7:0] m;
      m = muo[7:0];
      check("model_uo", uo_out, m);
      check("uio_oe", uio_oe, 8'h00);
      check("uio_out", uio_out, 8'h00);
    end
  end

  initial begin
    // Reset held for two cycles
    cmd(0, 0, 0, 0, 1'b1, 1'b1);
    cmd(0, 0, 0, 0, 1'b1, 1'b1);
    check_en = 1'b1;
    expect_uo("reset_uo", 8'h00);
    check("reset_oe", uio_oe, 8'h00);
    cmd(7, 0, 0, 0); expect_uo("reset_stat", 8'h20);

    // Basic MAC
    cmd(1, 0, 0, 3);
    cmd(1, 1, 0, -2);
    cmd(2, 0, 0, 10);
    cmd(2, 1, 0, 5);
    cmd(5, 0, 0, 0); expect_uo("basic_out", 8'h14);

    // Sign and ReLU
    cmd(3, 0, 0, 0);
    cmd(4, 0, 0, -1);
    cmd(5, 0, 0, 0); expect_uo("relu_neg", 8'h00);
    cmd(6, 0, 0, 0); expect_uo("outs_sh0", 8'h80);
    cmd(6, 0, 7, 0); expect_uo("outs_sh7", 8'hfe);
    cmd(7, 0, 0, 0); expect_uo("stat_neg", 8'h40);

    // Shift and clamp
    cmd(3, 0, 0, 0);
    cmd(1, 2, 0, 100);
    cmd(2, 2, 0, 10);
    cmd(5, 0, 3, 0); expect_uo("out_sh3", 8'd125);
    cmd(5, 0, 0, 0); expect_uo("out_clamp", 8'd127);
    cmd(7, 0, 0, 0); expect_uo("stat_pos", 8'h00);

    // Positive saturation, then one more MAC at the rail
    cmd(3, 0, 0, 0);
    cmd(1, 3, 0, -128);
    for (int i = 0; i < 34; i++) cmd(2, 3, 0, -128);
    cmd(7, 0, 0, 0); expect_uo("stat_sat", 8'h80);
    cmd(5, 0, 7, 0); expect_uo("sat_out_sh7", 8'h7f);
    cmd(3, 0, 0, 0);
    cmd(7, 0, 0, 0); expect_uo("stat_clr", 8'h20);

    // Negative saturation
    cmd(1, 2, 0, 127);
    for (int i = 0; i < 34; i++) cmd(2, 2, 0, -128);
    cmd(6, 0, 7, 0); expect_uo("neg_rail_sh7", 8'h80);
    cmd(7, 0, 0, 0); expect_uo("stat_negsat", 8'hc0);

    // ena=0 gating: w0 stays 3, uo_out holds
    cmd(1, 0, 0, 50, 1'b0);
    cmd(5, 0, 0, 0, 1'b0); expect_uo("gated_hold", 8'hc0);
    cmd(3, 0, 0, 0);
    cmd(2, 0, 0, 1);
    cmd(5, 0, 0, 0); expect_uo("gated_w0", 8'h03);

    // Reset mid-sequence
    cmd(2, 0, 0, 10);
    cmd(2, 1, 0, 10);
    cmd(0, 0, 0, 0, 1'b1, 1'b1); expect_uo("midrst_uo", 8'h00);
    cmd(7, 0, 0, 0); expect_uo("midrst_stat", 8'h20);
    for (int i = 0; i < 4; i++) cmd(2, i, 0, 10);
    cmd(7, 0, 0, 0); expect_uo("midrst_weights", 8'h20);

    // Randomized traffic, checked each cycle by the compare process
    for (int n = 0; n < 2000; n++) begin
      int op, idx, sh, x;
      bit en, rst;
      op  = int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) op = 2;
      idx = int'($urandom_range(0, 3));
      sh  = int'($urandom_range(0, 7));
      x   = int'($urandom_range(0, 255)) - 128;
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
      cmd(op, idx, sh, x, en, rst);
    end

    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
